// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, sign extension and load-use stall.
// Bubbles zero the whole register so EX traces stay deterministic.
module id_ex_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [31:0]            id_instr,
    input  logic [31:0]            id_pc_plus4,
    input  logic [31:0]            read_data1,
    input  logic [31:0]            read_data2,
    output logic [4:0]             read_reg1,
    output logic [4:0]             read_reg2,
    input  logic                   flush,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ex_valid,
    output logic                   ex_reg_write,
    output logic                   ex_mem_to_reg,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_branch,
    output logic                   ex_alu_src,
    output logic                   ex_reg_dst,
    output logic [1:0]             ex_alu_op,
    output logic [31:0]            ex_pc_plus4,
    output logic [31:0]            ex_rd1,
    output logic [31:0]            ex_rd2,
    output logic [31:0]            ex_imm,
    output logic [4:0]             ex_rs,
    output logic [4:0]             ex_rt,
    output logic [4:0]             ex_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] imm_ext;
    ctrl_t       dec, ex_ctrl;
    logic        uses_rt;
    logic        load_use;
    logic        stall;
    logic        bubble;

    assign opcode    = id_instr[31:26];
    assign rs        = id_instr[25:21];
    assign rt        = id_instr[20:16];
    assign rd        = id_instr[15:11];
    assign imm_ext   = {{16{id_instr[15]}}, id_instr[15:0]};
    assign read_reg1 = rs;
    assign read_reg2 = rt;

    always_comb begin
        dec     = '0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                uses_rt    = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_J:    ;
            default: ;
        endcase
        dest = dec.reg_dst ? rd : rt;
        // $0 is not write-protected in the register file
        if (dest == 5'd0) dec.reg_write = 1'b0;
    end

    assign load_use = id_valid & ex_valid & ex_ctrl.mem_read
                    & (ex_rt != 5'd0)
                    & ((ex_rt == rs) | (uses_rt & (ex_rt == rt)));
    assign stall      = load_use & ~flush;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign bubble     = flush | load_use;

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc_plus4 <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
        end else begin
            ex_valid    <= id_valid;
            ex_ctrl     <= id_valid ? dec : '0;
            ex_pc_plus4 <= id_pc_plus4;
            ex_rd1      <= read_data1;
            ex_rd2      <= read_data2;
            ex_imm      <= imm_ext;
            ex_rs       <= rs;
            ex_rt       <= rt;
            ex_rd       <= rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed MIPS sequences against a per-cycle model.
// A second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc_plus4 = '0;
    logic [31:0] read_data1 = '0;
    logic [31:0] read_data2 = '0;
    logic        flush = 1'b0;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        br;
        logic        asrc;
        logic        rdst;
        logic [1:0]  op;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_t;

    logic [4:0]  rr1, rr2, rr1_b, rr2_b;
    logic        pcw, ifw, pcw_b, ifw_b;
    logic        v, rw, m2r, mr, mw, br, asrc, rdst;
    logic        v_b, rw_b, m2r_b, mr_b, mw_b, br_b, asrc_b, rdst_b;
    logic [1:0]  op, op_b;
    logic [31:0] pc, d1, d2, imm, pc_b, d1_b, d2_b, imm_b;
    logic [4:0]  rs, rt, rd, rs_b, rt_b, rd_b;
    logic [15:0] cnt;
    logic [1:0]  cnt_b;
    ex_t         got, got_b;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .read_data1(read_data1), .read_data2(read_data2),
        .read_reg1(rr1), .read_reg2(rr2), .flush(flush),
        .pc_write(pcw), .ifid_write(ifw),
        .ex_valid(v), .ex_reg_write(rw), .ex_mem_to_reg(m2r),
        .ex_mem_read(mr), .ex_mem_write(mw), .ex_branch(br),
        .ex_alu_src(asrc), .ex_reg_dst(rdst), .ex_alu_op(op),
        .ex_pc_plus4(pc), .ex_rd1(d1), .ex_rd2(d2), .ex_imm(imm),
        .ex_rs(rs), .ex_rt(rt), .ex_rd(rd), .stall_cnt(cnt)
    );

    id_ex_stage #(.STALL_CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .read_data1(read_data1), .read_data2(read_data2),
        .read_reg1(rr1_b), .read_reg2(rr2_b), .flush(flush),
        .pc_write(pcw_b), .ifid_write(ifw_b),
        .ex_valid(v_b), .ex_reg_write(rw_b), .ex_mem_to_reg(m2r_b),
        .ex_mem_read(mr_b), .ex_mem_write(mw_b), .ex_branch(br_b),
        .ex_alu_src(asrc_b), .ex_reg_dst(rdst_b), .ex_alu_op(op_b),
        .ex_pc_plus4(pc_b), .ex_rd1(d1_b), .ex_rd2(d2_b), .ex_imm(imm_b),
        .ex_rs(rs_b), .ex_rt(rt_b), .ex_rd(rd_b), .stall_cnt(cnt_b)
    );

    assign got   = {v, rw, m2r, mr, mw, br, asrc, rdst, op,
                    pc, d1, d2, imm, rs, rt, rd};
    assign got_b = {v_b, rw_b, m2r_b, mr_b, mw_b, br_b, asrc_b, rdst_b, op_b,
                    pc_b, d1_b, d2_b, imm_b, rs_b, rt_b, rd_b};

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    ex_t m;
    int  m_cnt = 0;
    int  m_cnt_b = 0;
    bit  started = 0;

    function automatic bit reads_rt(logic [5:0] opc);
        return opc == 6'h00 || opc == 6'h2b || opc == 6'h04;
    endfunction

    function automatic bit model_lu();
        logic [4:0] s = id_instr[25:21];
        logic [4:0] t = id_instr[20:16];
        return id_valid && m.valid && m.mr && m.rt != 0 &&
               (m.rt == s || (reads_rt(id_instr[31:26]) && m.rt == t));
    endfunction

    function automatic ex_t model_capture();
        ex_t e = '0;
        logic [4:0] dst;
        e.valid = id_valid;
        e.pc    = id_pc_plus4;
        e.d1    = read_data1;
        e.d2    = read_data2;
        e.imm   = {{16{id_instr[15]}}, id_instr[15:0]};
        e.rs    = id_instr[25:21];
        e.rt    = id_instr[20:16];
        e.rd    = id_instr[15:11];
        if (id_valid) begin
            case (id_instr[31:26])
                6'h00: begin e.rdst = 1; e.rw = 1; e.op = 2'b10; end
                6'h23: begin e.asrc = 1; e.m2r = 1; e.mr = 1; e.rw = 1; end
                6'h2b: begin e.asrc = 1; e.mw = 1; end
                6'h04: begin e.br = 1; e.op = 2'b01; end
                6'h08: begin e.asrc = 1; e.rw = 1; end
                default: ;
            endcase
            dst = e.rdst ? e.rd : e.rt;
            if (dst == 0) e.rw = 0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        bit lu;
        lu = model_lu();
        if (!rst_n) begin
            m = '0;
            m_cnt = 0;
            m_cnt_b = 0;
        end else begin
            if (lu && !flush) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_b < 3) m_cnt_b++;
            end
            if (flush || lu) m = '0;
            else m = model_capture();
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            bit exp_pcw;
            exp_pcw = !(model_lu() && !flush);
            chk("m_ex_valid", 32'(v), 32'(m.valid));
            chk("m_ctrl", {23'd0, rw, m2r, mr, mw, br, asrc, rdst, op},
                {23'd0, m.rw, m.m2r, m.mr, m.mw, m.br, m.asrc, m.rdst, m.op});
            chk("m_pc", pc, m.pc);
            chk("m_rd1", d1, m.d1);
            chk("m_rd2", d2, m.d2);
            chk("m_imm", imm, m.imm);
            chk("m_regs", {17'd0, rs, rt, rd}, {17'd0, m.rs, m.rt, m.rd});
            chk("m_pc_write", 32'(pcw), 32'(exp_pcw));
            chk("m_ifid_write", 32'(ifw), 32'(exp_pcw));
            chk("m_read_regs", {22'd0, rr1, rr2},
                {22'd0, id_instr[25:21], id_instr[20:16]});
            chk("m_stall_cnt", 32'(cnt), 32'(m_cnt));
            chk("m_stall_cnt_w2", 32'(cnt_b), 32'(m_cnt_b));
            total++;
            if (got_b !== m) begin
                bad++;
                $display("FAIL m_w2_bundle: got=%h want=%h at %0t",
                         got_b, m, $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] LW8    = 32'h8D28_0004;
    localparam logic [31:0] ADD    = 32'h010B_5020;
    localparam logic [31:0] SW8    = 32'hAD28_0000;
    localparam logic [31:0] ADDI12 = 32'h21AC_0005;
    localparam logic [31:0] LW0    = 32'h8D20_0000;
    localparam logic [31:0] ADD1   = 32'h0000_0820;
    localparam logic [31:0] ADDI0  = 32'h2020_0003;
    localparam logic [31:0] BEQ    = 32'h1022_FFFF;
    localparam logic [31:0] JMP    = 32'h0800_0010;

    task automatic set_in(logic vv, logic [31:0] ins, logic fl);
        id_valid    = vv;
        id_instr    = ins;
        flush       = fl;
        read_data1  = $urandom;
        read_data2  = $urandom;
        id_pc_plus4 = id_pc_plus4 + 32'd4;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1, LW8, 0);
        tick();
        set_in(1, 32'hDEAD_BEEF, 1);
        tick();
        chk("rst_ex_valid", 32'(v), 0);
        chk("rst_ex_rd1", d1, 0);
        chk("rst_ex_imm", imm, 0);
        chk("rst_stall_cnt", 32'(cnt), 0);
        set_in(1, ADD, 0);
        chk("rst_pc_write", 32'(pcw), 1);
        rst_n = 1'b1;

        set_in(1, LW8, 0);
        tick();
        chk("lw_mem_read", 32'(mr), 1);
        chk("lw_rt", 32'(rt), 8);
        chk("lw_imm", imm, 4);
        set_in(1, ADD, 0);
        chk("lu_pc_write", 32'(pcw), 0);
        chk("lu_ifid_write", 32'(ifw), 0);
        tick();
        chk("lu_bubble", 32'(v), 0);
        chk("lu_cnt", 32'(cnt), 1);
        chk("lu_release", 32'(pcw), 1);
        set_in(1, ADD, 0);
        tick();
        chk("add_rs", 32'(rs), 8);
        chk("add_rd", 32'(rd), 10);
        chk("add_alu_op", 32'(op), 2);
        chk("add_reg_write", 32'(rw), 1);

        set_in(1, LW8, 0);
        tick();
        set_in(1, SW8, 0);
        chk("sw_stall", 32'(pcw), 0);
        tick();
        chk("sw_bubble", 32'(v), 0);
        set_in(1, SW8, 0);
        tick();
        chk("sw_mem_write", 32'(mw), 1);
        chk("sw_reg_write", 32'(rw), 0);
        chk("sw_cnt", 32'(cnt), 2);

        set_in(1, LW8, 0);
        tick();
        set_in(1, ADDI12, 0);
        chk("addi_no_stall", 32'(pcw), 1);
        tick();
        chk("addi_rt", 32'(rt), 12);
        chk("addi_imm", imm, 5);

        set_in(1, LW0, 0);
        tick();
        set_in(1, ADD1, 0);
        chk("lw0_no_stall", 32'(pcw), 1);
        tick();
        chk("add1_valid", 32'(v), 1);
        chk("add1_rd", 32'(rd), 1);
        set_in(1, 32'h0, 0);
        tick();
        chk("nop_valid", 32'(v), 1);
        chk("nop_reg_write", 32'(rw), 0);
        set_in(1, ADDI0, 0);
        tick();
        chk("addi0_reg_write", 32'(rw), 0);
        chk("addi0_alu_src", 32'(asrc), 1);
        set_in(1, BEQ, 0);
        tick();
        chk("beq_imm", imm, 32'hFFFF_FFFF);
        chk("beq_branch", 32'(br), 1);
        chk("beq_alu_op", 32'(op), 1);
        set_in(1, JMP, 0);
        tick();
        chk("j_valid", 32'(v), 1);
        set_in(0, ADD, 0);
        tick();
        chk("inv_valid", 32'(v), 0);
        chk("inv_reg_write", 32'(rw), 0);

        set_in(1, LW8, 0);
        tick();
        set_in(1, ADD, 1);
        chk("flush_pc_write", 32'(pcw), 1);
        tick();
        chk("flush_bubble", 32'(v), 0);
        chk("flush_rd1", d1, 0);
        chk("flush_cnt", 32'(cnt), 2);

        for (int k = 0; k < 3; k++) begin
            set_in(1, LW8, 0);
            tick();
            set_in(1, ADD, 0);
            tick();
            set_in(1, ADD, 0);
            tick();
            if (k == 0) begin
                chk("sat_w2_3rd", 32'(cnt_b), 3);
                chk("cnt_3rd", 32'(cnt), 3);
            end
        end
        chk("sat_w2_5th", 32'(cnt_b), 3);
        chk("cnt_5th", 32'(cnt), 5);

        set_in(1, LW8, 0);
        tick();
        rst_n = 1'b0;
        set_in(1, ADD, 0);
        tick();
        chk("midrst_valid", 32'(v), 0);
        chk("midrst_cnt", 32'(cnt), 0);
        chk("midrst_pc_write", 32'(pcw), 1);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
